bus_scheduler: RTL and testbench
================================

BUS_SCHEDULER -- requirements
Module: bus_scheduler

Interface
REQ-001 SHALL have parameter SLAVE_ADDR_BITS, default 2: number of serial slave-address bits captured per transaction.
REQ-002 SHALL have parameter HOLD_MAX, default 16: maximum DATA cycles while the other master is requesting.
REQ-003 SHALL have parameter TIMEOUT, default 32: maximum WAIT_READY cycles before abort.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: system reset, asynchronous, active-low.
REQ-006 SHALL have ports m1_request and m2_request, input, 1 bit each: master request, held high for the whole transaction.
REQ-007 SHALL have ports m1_slave_select and m2_slave_select, input, 1 bit each: serial slave address, LSB first, driven after grant.
REQ-008 SHALL have port s_ready, input, 1 bit: ready from the addressed slave, muxed externally.
REQ-009 SHALL have ports m1_grant and m2_grant, output, 1 bit each: bus ownership grant.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port bus_grant, output, 2 bits: master-mux select; 01 = M1, 10 = M2, 00 = none.
REQ-012 SHALL have port slave_grant, output, SLAVE_ADDR_BITS bits: slave-mux select.
REQ-013 SHALL have port timeout_err, output, 1 bit: one-cycle abort pulse.

Function
REQ-014 SHALL implement states IDLE, ADDR, WAIT_READY, DATA, RELEASE; all outputs registered.
REQ-015 In IDLE, a sampled request SHALL move to ADDR; the winner's grant and bus_grant SHALL be visible the next cycle.
REQ-016 On simultaneous requests in IDLE, the master not granted last SHALL win; last-winner SHALL reset to M2, so M1 wins the first tie.
REQ-017 In ADDR, the owner's slave_select SHALL be sampled on each of SLAVE_ADDR_BITS consecutive edges, starting with the first edge on which the grant is high; bit i goes to slave_grant[i].
REQ-018 After the last address bit, the state SHALL go to WAIT_READY with slave_grant fully updated.
REQ-019 In WAIT_READY, s_ready sampled high SHALL move to DATA.
REQ-020 In DATA, the owner's request sampled low SHALL move to RELEASE.
REQ-021 In DATA, a hold counter SHALL count cycles while the other master requests; on reaching HOLD_MAX, DATA SHALL move to RELEASE (preemption).
REQ-022 The hold counter SHALL clear on entry to DATA and SHALL NOT advance while the other master is idle.
REQ-023 An owner request dropping in ADDR or WAIT_READY SHALL move to RELEASE.
REQ-024 RELEASE SHALL last one cycle:
- grants, bus_grant and slave_grant driven to 0
- last-winner updated to the owner
- next state IDLE
REQ-025 A master's grant SHALL never be high in the same cycle as the other master's grant.
REQ-026 Counters SHALL saturate, never wrap.

Reset
REQ-027 Reset low SHALL immediately force:
- state IDLE
- m1_grant, m2_grant, busy, timeout_err = 0
- bus_grant = 00, slave_grant = 0
- last-winner = M2
- all counters = 0
This SHALL apply from any state, including mid-transaction.
REQ-028 After reset release, the first request SHALL be sampled on the first rising edge with reset high.

Configuration
REQ-029 Macro BUS_SCHEDULER_TIMEOUT_EN defined: a WAIT_READY counter SHALL clear on entry; on reaching TIMEOUT, timeout_err SHALL pulse high one cycle and the state SHALL go to RELEASE.
REQ-030 Macro BUS_SCHEDULER_TIMEOUT_EN undefined: WAIT_READY SHALL wait indefinitely, timeout_err SHALL be tied 0, and no timeout counter SHALL exist.

Verification
REQ-031 M1 request only; serial bits 1,0; s_ready after 3 cycles; drop request after 5 DATA cycles -> m1_grant=1, bus_grant=01, slave_grant=01, busy=1 throughout; RELEASE then IDLE with all outputs 0.
REQ-032 M1 and M2 request on the same edge after reset -> M1 granted; repeat the tie after completion -> M2 granted.
REQ-033 M2 owns DATA and M1 requests continuously, HOLD_MAX=16 -> M2 preempted after 16 DATA cycles; one RELEASE cycle; M1 granted next.
REQ-034 TIMEOUT_EN defined, TIMEOUT=32, s_ready held 0 -> timeout_err single pulse on the 32nd WAIT_READY cycle, then RELEASE; macro undefined -> stays in WAIT_READY for 100 cycles, timeout_err=0.
REQ-035 Reset asserted low mid-ADDR and mid-DATA -> all outputs 0 asynchronously, before the next clock edge; after release, a tie goes to M1.
REQ-036 Owner drops request in ADDR after 1 of 2 bits -> RELEASE next cycle; slave_grant=0; the other requester is then granted.

Source files
------------

// File: rtl/bus_scheduler.sv
// ---------------------------------------------------------------------------
// bus_scheduler
//   Two-master / multi-slave bus arbiter. A request in IDLE grants one
//   master (ties go to the master not granted last). The owner then shifts
//   in a serial slave address (LSB first), waits for s_ready, and owns the
//   data phase until it drops its request or is preempted after HOLD_MAX
//   contended DATA cycles. A one-cycle RELEASE clears all selects.
//
//   Optional feature: define BUS_SCHEDULER_TIMEOUT_EN to abort WAIT_READY
//   after TIMEOUT cycles with a one-cycle timeout_err pulse. Without it,
//   WAIT_READY waits indefinitely and timeout_err is tied low.
//
// Ports
//   clk                     system clock, rising edge
//   reset                   asynchronous active-low reset
//   m1/m2_request           master request, held for the whole transaction
//   m1/m2_slave_select      serial slave address, LSB first, after grant
//   s_ready                 ready from the addressed slave
//   m1/m2_grant             bus ownership grant (mutually exclusive)
//   busy                    high in every state except IDLE
//   bus_grant               master mux select: 01 = M1, 10 = M2, 00 = none
//   slave_grant             slave mux select
//   timeout_err             one-cycle WAIT_READY abort pulse
// ---------------------------------------------------------------------------
module bus_scheduler #(
   parameter int SLAVE_ADDR_BITS = 2,
   parameter int HOLD_MAX        = 16,
   parameter int TIMEOUT         = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       m1_request,
   input  logic                       m2_request,
   input  logic                       m1_slave_select,
   input  logic                       m2_slave_select,
   input  logic                       s_ready,
   output logic                       m1_grant,
   output logic                       m2_grant,
   output logic                       busy,
   output logic [1:0]                 bus_grant,
   output logic [SLAVE_ADDR_BITS-1:0] slave_grant,
   output logic                       timeout_err
);

   localparam int AW = (SLAVE_ADDR_BITS > 1) ? $clog2(SLAVE_ADDR_BITS) : 1;
   localparam int HW = $clog2(HOLD_MAX + 1);

   if (SLAVE_ADDR_BITS < 1 || HOLD_MAX < 1 || TIMEOUT < 1) begin : g_bad_cfg
      $error("bus_scheduler: SLAVE_ADDR_BITS, HOLD_MAX and TIMEOUT must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WAIT, S_DATA, S_REL
   } state_e;

   state_e                     state_q;
   logic                       owner_q;      // 0 = M1, 1 = M2
   logic                       last_q;       // last winner, 0 = M1, 1 = M2
   logic                       m1_grant_q, m2_grant_q, busy_q;
   logic [1:0]                 bus_grant_q;
   logic [SLAVE_ADDR_BITS-1:0] slave_grant_q;
   logic [AW-1:0]              addr_cnt_q;
   logic [HW-1:0]              hold_cnt_q;

   logic own_req, oth_req, own_sel, idle_win;

   assign own_req = owner_q ? m2_request      : m1_request;
   assign oth_req = owner_q ? m1_request      : m2_request;
   assign own_sel = owner_q ? m2_slave_select : m1_slave_select;
   // On a tie the master that did not win last time gets the bus.
   assign idle_win = (m1_request && m2_request) ? ~last_q : m2_request;

`ifdef BUS_SCHEDULER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt_q;
   logic          timeout_err_q;
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         owner_q       <= 1'b0;
         last_q        <= 1'b1;
         m1_grant_q    <= 1'b0;
         m2_grant_q    <= 1'b0;
         busy_q        <= 1'b0;
         bus_grant_q   <= 2'b00;
         slave_grant_q <= '0;
         addr_cnt_q    <= '0;
         hold_cnt_q    <= '0;
`ifdef BUS_SCHEDULER_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
`ifdef BUS_SCHEDULER_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (m1_request || m2_request) begin
                  state_q     <= S_ADDR;
                  owner_q     <= idle_win;
                  m1_grant_q  <= ~idle_win;
                  m2_grant_q  <= idle_win;
                  bus_grant_q <= idle_win ? 2'b10 : 2'b01;
                  busy_q      <= 1'b1;
                  addr_cnt_q  <= '0;
               end
            end
            S_ADDR: begin
               if (!own_req) begin
                  state_q <= S_REL;
                  m1_grant_q <= 1'b0; m2_grant_q <= 1'b0;
                  bus_grant_q <= 2'b00; slave_grant_q <= '0;
               end else begin
                  slave_grant_q[addr_cnt_q] <= own_sel;
                  if (addr_cnt_q == AW'(SLAVE_ADDR_BITS - 1)) begin
                     state_q <= S_WAIT;
`ifdef BUS_SCHEDULER_TIMEOUT_EN
                     tmo_cnt_q     <= '0;
                     // Registered pulse must already be high in cycle 1.
                     timeout_err_q <= (TIMEOUT == 1);
`endif
                  end else begin
                     addr_cnt_q <= addr_cnt_q + 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (!own_req) begin
                  state_q <= S_REL;
                  m1_grant_q <= 1'b0; m2_grant_q <= 1'b0;
                  bus_grant_q <= 2'b00; slave_grant_q <= '0;
               end
`ifdef BUS_SCHEDULER_TIMEOUT_EN
               else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                  // Last allowed cycle just ended: abort, even if s_ready.
                  state_q <= S_REL;
                  m1_grant_q <= 1'b0; m2_grant_q <= 1'b0;
                  bus_grant_q <= 2'b00; slave_grant_q <= '0;
               end
`endif
               else if (s_ready) begin
                  state_q    <= S_DATA;
                  hold_cnt_q <= '0;
               end
`ifdef BUS_SCHEDULER_TIMEOUT_EN
               else begin
                  if (tmo_cnt_q != TW'(TIMEOUT)) tmo_cnt_q <= tmo_cnt_q + 1'b1;
                  // Raise the pulse so it is visible during the final cycle.
                  timeout_err_q <= (tmo_cnt_q == TW'(TIMEOUT - 2));
               end
`endif
            end
            S_DATA: begin
               if (!own_req || (oth_req && hold_cnt_q == HW'(HOLD_MAX - 1))) begin
                  state_q <= S_REL;
                  m1_grant_q <= 1'b0; m2_grant_q <= 1'b0;
                  bus_grant_q <= 2'b00; slave_grant_q <= '0;
               end else if (oth_req && hold_cnt_q != HW'(HOLD_MAX)) begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            S_REL: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               last_q  <= owner_q;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign m1_grant    = m1_grant_q;
   assign m2_grant    = m2_grant_q;
   assign busy        = busy_q;
   assign bus_grant   = bus_grant_q;
   assign slave_grant = slave_grant_q;

endmodule

// File: tb/tb_bus_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bus_scheduler
//   Table of directed vectors, hand-written corner sequences (preemption,
//   async reset, drop in ADDR, WAIT_READY timeout / indefinite wait) and a
//   randomized run, all checked every cycle against a transaction-level
//   reference model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_bus_scheduler;

   localparam int SAB  = 2;
   localparam int HM   = 16;
   localparam int TOUT = 32;
   localparam int OW   = 6 + SAB;
`ifdef BUS_SCHEDULER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk, rst_n, r1, r2, s1, s2, rdy;
   logic m1_grant, m2_grant, busy, timeout_err;
   logic [1:0] bus_grant;
   logic [SAB-1:0] slave_grant;

   bus_scheduler #(.SLAVE_ADDR_BITS(SAB), .HOLD_MAX(HM), .TIMEOUT(TOUT)) dut (
      .clk(clk), .reset(rst_n),
      .m1_request(r1), .m2_request(r2),
      .m1_slave_select(s1), .m2_slave_select(s2),
      .s_ready(rdy),
      .m1_grant(m1_grant), .m2_grant(m2_grant), .busy(busy),
      .bus_grant(bus_grant), .slave_grant(slave_grant),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0, nerr = 0;

   // ---------------- reference model ----------------
   localparam int P_IDLE = 0, P_ADDR = 1, P_WAIT = 2, P_DATA = 3, P_REL = 4;
   int ph, own, last, bits, wcnt, hold;
   logic [SAB-1:0] msg;

   function automatic void model_reset();
      ph = P_IDLE; own = 0; last = 2; bits = 0; wcnt = 0; hold = 0; msg = '0;
   endfunction

   function automatic void model_edge();
      logic rq_own, rq_oth, sel_own;
      rq_own  = (own == 1) ? r1 : r2;
      rq_oth  = (own == 1) ? r2 : r1;
      sel_own = (own == 1) ? s1 : s2;
      case (ph)
         P_IDLE: if (r1 || r2) begin
            own  = (r1 && r2) ? ((last == 2) ? 1 : 2) : (r1 ? 1 : 2);
            ph   = P_ADDR; bits = 0; msg = '0;
         end
         P_ADDR: if (!rq_own) ph = P_REL;
                 else begin
                    msg[bits] = sel_own; bits++;
                    if (bits == SAB) begin ph = P_WAIT; wcnt = 0; end
                 end
         P_WAIT: if (!rq_own) ph = P_REL;
                 else begin
                    wcnt++;
                    if (TO_EN && wcnt == TOUT) ph = P_REL;
                    else if (rdy) begin ph = P_DATA; hold = 0; end
                 end
         P_DATA: if (!rq_own) ph = P_REL;
                 else if (rq_oth) begin hold++; if (hold == HM) ph = P_REL; end
         default: begin last = own; own = 0; ph = P_IDLE; end
      endcase
      if (ph == P_REL) msg = '0;
   endfunction

   function automatic logic [OW-1:0] model_out();
      logic g1, g2, act;
      act = (ph == P_ADDR) || (ph == P_WAIT) || (ph == P_DATA);
      g1  = act && own == 1;
      g2  = act && own == 2;
      return {g1, g2, ph != P_IDLE, g2, g1, msg,
              TO_EN && ph == P_WAIT && (wcnt + 1) == TOUT};
   endfunction

   function automatic logic [OW-1:0] dut_out();
      return {m1_grant, m2_grant, busy, bus_grant, slave_grant, timeout_err};
   endfunction

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // One clock: model sees the same pre-edge inputs as the DUT.
   task automatic step(input string nm);
      @(posedge clk);
      model_edge();
      #1;
      cmp(nm, 32'(dut_out()), 32'(model_out()));
   endtask

   task automatic set_in(input logic a, b, c, d, e);
      r1 = a; r2 = b; s1 = c; s2 = d; rdy = e;
   endtask

   task automatic async_reset(input string nm);
      #1 rst_n = 1'b0;
      #1 cmp(nm, 32'(dut_out()), 32'(0));
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic r1, r2, s1, s2, rdy;
      logic [OW-1:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic a, b, c, d, e,
                               input logic g1, g2, bz, input logic [1:0] bg,
                               input logic [SAB-1:0] sg);
      return '{a, b, c, d, e, {g1, g2, bz, bg, sg, 1'b0}};
   endfunction

   vec_t tv[20];
   int   n;

   initial begin
      //           r1 r2 s1 s2 rdy  g1 g2 bsy bg     sg
      tv[0]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 2'b01, 2'b00); // grant M1
      tv[1]  = mk(1, 0, 1, 0, 0,   1, 0, 1, 2'b01, 2'b01); // bit0 = 1
      tv[2]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 2'b01, 2'b01); // bit1 = 0 -> WAIT
      tv[3]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 2'b01, 2'b01);
      tv[4]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 2'b01, 2'b01);
      tv[5]  = mk(1, 0, 0, 0, 1,   1, 0, 1, 2'b01, 2'b01); // ready -> DATA
      tv[6]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 2'b01, 2'b01);
      tv[7]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 2'b01, 2'b01);
      tv[8]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 2'b01, 2'b01);
      tv[9]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 2'b01, 2'b01);
      tv[10] = mk(0, 0, 0, 0, 0,   0, 0, 1, 2'b00, 2'b00); // RELEASE
      tv[11] = mk(0, 0, 0, 0, 0,   0, 0, 0, 2'b00, 2'b00); // IDLE
      tv[12] = mk(1, 1, 0, 0, 0,   0, 1, 1, 2'b10, 2'b00); // tie -> M2
      tv[13] = mk(1, 1, 0, 1, 0,   0, 1, 1, 2'b10, 2'b01);
      tv[14] = mk(1, 1, 0, 1, 0,   0, 1, 1, 2'b10, 2'b11); // WAIT
      tv[15] = mk(1, 0, 0, 0, 0,   0, 0, 1, 2'b00, 2'b00); // drop in WAIT
      tv[16] = mk(1, 0, 0, 0, 0,   0, 0, 0, 2'b00, 2'b00);
      tv[17] = mk(1, 0, 0, 0, 0,   1, 0, 1, 2'b01, 2'b00); // M1 granted
      tv[18] = mk(0, 0, 0, 0, 0,   0, 0, 1, 2'b00, 2'b00); // drop in ADDR
      tv[19] = mk(0, 0, 0, 0, 0,   0, 0, 0, 2'b00, 2'b00);

      rst_n = 1'b0; set_in(0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 cmp("reset_state", 32'(dut_out()), 32'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         set_in(tv[i].r1, tv[i].r2, tv[i].s1, tv[i].s2, tv[i].rdy);
         step($sformatf("vec%0d_model", i));
         cmp($sformatf("vec%0d", i), 32'(dut_out()), 32'(tv[i].exp));
      end

      // ---- preemption: M2 in DATA, M1 requesting continuously ----
      set_in(0, 1, 0, 0, 0); step("pre_grant");
      cmp("pre_m2_granted", {m2_grant, bus_grant}, 3'b110);
      s2 = 1'b0; step("pre_a0");
      s2 = 1'b1; step("pre_a1");
      r1 = 1'b1; rdy = 1'b1; step("pre_data");
      rdy = 1'b0;
      n = 1;
      while (m2_grant && n < 40) begin
         step("pre_hold");
         if (m2_grant) n++;
      end
      cmp("pre_data_cycles", 32'(n), 32'(HM));
      cmp("pre_release", {busy, m1_grant, m2_grant, slave_grant}, {3'b100, {SAB{1'b0}}});
      step("pre_idle");
      step("pre_m1");
      cmp("pre_m1_granted", {m1_grant, bus_grant}, 3'b101);

      // ---- M1 to DATA, then async reset mid-DATA ----
      step("m1_a0"); step("m1_a1");
      rdy = 1'b1; step("m1_data"); rdy = 1'b0;
      cmp("m1_in_data", {m1_grant, busy}, 2'b11);
      r2 = 1'b1;
      async_reset("rst_mid_data");
      step("rst_tie");
      cmp("rst_tie_m1", {m1_grant, m2_grant, bus_grant}, 4'b1001);

      // ---- owner drops after 1 of 2 address bits ----
      s1 = 1'b1; step("drop_a0");
      cmp("drop_a0_sg", 32'(slave_grant), 32'(1));
      r1 = 1'b0; step("drop_rel");
      cmp("drop_rel", {busy, m1_grant, m2_grant, slave_grant}, {3'b100, {SAB{1'b0}}});
      step("drop_idle");
      step("drop_m2");
      cmp("drop_m2_granted", {m2_grant, bus_grant}, 3'b110);

      // ---- async reset mid-ADDR ----
      r1 = 1'b1;
      async_reset("rst_mid_addr");
      step("rst2_tie");
      cmp("rst2_tie_m1", {m1_grant, bus_grant}, 3'b101);

      // ---- WAIT_READY with s_ready held low ----
      set_in(1, 0, 0, 0, 0);
      step("w_a0"); step("w_a1");
      if (TO_EN) begin
         for (int k = 1; k <= TOUT; k++) begin
            cmp($sformatf("tmo_pulse_c%0d", k), 32'(timeout_err), 32'(k == TOUT));
            step("tmo_wait");
         end
         cmp("tmo_release", {busy, m1_grant, timeout_err}, 3'b100);
      end else begin
         for (int k = 1; k <= 100; k++) begin
            cmp("wait_forever", {busy, m1_grant, timeout_err}, 3'b110);
            step("wait_hold");
         end
      end
      r1 = 1'b0; step("w_rel"); step("w_idle");

      // ---- randomized traffic ----
      for (int c = 0; c < 3000; c++) begin
         if (r1) r1 = ($urandom_range(15) != 0); else r1 = ($urandom_range(2) == 0);
         if (r2) r2 = ($urandom_range(15) != 0); else r2 = ($urandom_range(2) == 0);
         s1  = 1'($urandom);
         s2  = 1'($urandom);
         rdy = ($urandom_range(3) == 0);
         step("rand");
         if (m1_grant && m2_grant) cmp("rand_mutex", 32'(1), 32'(0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
